cic_decimator: RTL and testbench
================================

Name: cic_decimator

Overview:
- Parametrised N-stage CIC decimator; successor to the single-stage CIC.
- Runtime-selectable decimation rate, configurable differential delay M, full-precision output with a strobe.
- Sits after the ADC sample-enable domain and ahead of the compensation FIR.
- Integrators run at the input sample rate (en_i); combs run at the decimated rate.

Parameters:
DIN_W, 11, signed input width
N, 3, number of integrator and comb stages (1..6)
R_MAX, 8, maximum decimation rate (power of two, >=2)
M, 1, comb differential delay (1 or 2)
RATE_W, 4, width of rate_i (must hold R_MAX)
DOUT_W, DIN_W+N*clog2(R_MAX*M), output/internal width (derived, default 20)

Ports:
clk_i     in   1       system clock
rst_i     in   1       asynchronous reset, active-high
en_i      in   1       input sample valid; one sample per cycle when high
data_i    in   DIN_W   signed input sample
rate_i    in   RATE_W  decimation rate request, 1..R_MAX
valid_o   out  1       one-cycle strobe, dout_o holds a new output
data_o    out  DOUT_W  signed decimated output

Behaviour:
- Reset (async on rst_i high, released synchronously internally):
  - all integrator, comb, delay and pipeline registers cleared to 0;
  - phase counter cleared to 0;
  - active rate loaded from rate_i at the first en_i after release;
  - valid_o = 0 and data_o = 0 during reset.
- Arithmetic:
  - data_i sign-extended to DOUT_W;
  - all adds/subtracts are DOUT_W two's complement, wrapping, with no saturation;
  - wrap in the integrators is intentional and cancels in the combs.
- Integrators:
  - On a cycle with en_i=1, stage1 <= stage1 + x, and stage k <= stage k + (new stage k-1), chained within the cycle.
  - After the edge, stage N holds the sum including the current sample.
  - With en_i=0, the integrators hold.
- Phase counter:
  - Counts accepted samples 0..rate-1.
  - On an en_i cycle with counter == rate-1: counter wraps to 0, a decimation strobe is issued, and rate_i is resampled as the next active rate.
  - rate_i is otherwise ignored; changes take effect only at the wrap boundary.
  - rate_i = 0 or rate_i > R_MAX clamps to R_MAX; rate 1 is a strobe on every en_i.
- Comb pipeline:
  - The strobe registers the stage-N integrator value into comb stage 1 on the next edge.
  - Each comb stage k is registered: y_k = x_k - x_k delayed by M decimated samples.
  - A stage advances and updates its M-deep delay line only when its valid bit is set; the valid bit shifts with the data.
- Latency:
  - valid_o rises N+1 cycles after the edge that accepted the rate-th sample.
  - data_o is held between strobes.
- Gain is (rate*M)^N; no output scaling.
  - Full-scale input never overflows data_o at rate = R_MAX.
  - Lower rates give lower gain; downstream normalises.
- en_i gaps: integrators and counter freeze; the comb pipeline keeps draining, so in-flight strobes still emerge on schedule.
- Back-to-back strobes (rate 1, en_i continuous) must be supported at one output per cycle.
- Reset mid-operation:
  - in-flight strobes are discarded and valid_o drops immediately;
  - the first output after release reflects only post-reset samples.

Test Plan:
- Reset, then rate_i=8 and en_i continuous with data_i=1:
  - outputs 120, 456, 512, 512, ...;
  - valid_o every 8 cycles;
  - first valid_o 4 cycles after the 8th sample's edge.
- Constant data_i=-1024 at rate 8:
  - data_o settles to -524288 (0x80000);
  - constant data_i=1023 settles to 523776;
  - no wrap errors.
- en_i toggling 1-0-1-0 with DC input 1:
  - same output sequence as continuous input;
  - valid_o spacing 16 cycles.
- rate_i changed from 8 to 4 mid-frame with DC input 1:
  - the current frame completes at 8 samples;
  - subsequent frames are 4 samples;
  - output settles to 64 after three rate-4 outputs.
- rate_i=1 with a ramp input:
  - valid_o high every cycle;
  - data_o equals data_i delayed by N+1 cycles after the settling transient.
- Assert rst_i for 1 cycle mid-frame:
  - valid_o=0 and data_o=0 immediately;
  - after release with DC input 1, the sequence restarts at 120.

Source files
------------

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: integrators at the input sample rate, registered combs at the decimated rate.
// Runtime rate select (1..R_MAX); full-precision wrapping arithmetic, no output scaling.
module cic_decimator #(
   parameter int DIN_W  = 11,
   parameter int N      = 3,
   parameter int R_MAX  = 8,
   parameter int M      = 1,
   parameter int RATE_W = 4,
   parameter int DOUT_W = DIN_W + N*$clog2(R_MAX*M)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [DIN_W-1:0]  data_i,
   input  logic [RATE_W-1:0] rate_i,
   output logic              valid_o,
   output logic [DOUT_W-1:0] data_o
);

   localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(R_MAX);

   // rst_i asserts everything at once; release is retimed to clk_i so no stage leaves reset early.
   logic [1:0] r_rst_sr;
   logic       w_rst;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_rst_sr <= 2'b11;
      else       r_rst_sr <= {r_rst_sr[0], 1'b0};
   end

   assign w_rst = r_rst_sr[1];

   logic [RATE_W-1:0] r_phase;
   logic [RATE_W-1:0] r_rate;
   logic              r_rate_vld;
   logic              r_strb;
   logic [RATE_W-1:0] w_rate_req;
   logic [RATE_W-1:0] w_rate_cur;
   logic              w_wrap;

   assign w_rate_req = (rate_i == '0 || rate_i > RATE_MAX) ? RATE_MAX : rate_i;
   // The very first sample after reset already uses the requested rate.
   assign w_rate_cur = r_rate_vld ? r_rate : w_rate_req;
   assign w_wrap     = en_i && (r_phase == w_rate_cur - RATE_W'(1));

   always_ff @(posedge clk_i or posedge w_rst) begin
      if (w_rst) begin
         r_phase    <= '0;
         r_rate     <= '0;
         r_rate_vld <= 1'b0;
         r_strb     <= 1'b0;
      end else begin
         r_strb <= w_wrap;
         if (en_i) begin
            r_rate_vld <= 1'b1;
            if (!r_rate_vld || w_wrap) r_rate <= w_rate_req;
            if (w_wrap) r_phase <= '0;
            else        r_phase <= r_phase + RATE_W'(1);
         end
      end
   end

   logic [DOUT_W-1:0] w_x;
   logic [DOUT_W-1:0] r_integ     [N];
   logic [DOUT_W-1:0] w_integ_nxt [N];

   assign w_x = {{(DOUT_W-DIN_W){data_i[DIN_W-1]}}, data_i};

   // Stage k's next value is x plus the current contents of stages 0..k.
   always_comb begin
      logic [DOUT_W-1:0] v_run;
      w_integ_nxt = '{default: '0};
      v_run = w_x;
      for (int k = 0; k < N; k++) begin
         v_run          = v_run + r_integ[k];
         w_integ_nxt[k] = v_run;
      end
   end

   always_ff @(posedge clk_i or posedge w_rst) begin
      if (w_rst) begin
         for (int k = 0; k < N; k++) r_integ[k] <= '0;
      end else if (en_i) begin
         for (int k = 0; k < N; k++) r_integ[k] <= w_integ_nxt[k];
      end
   end

   logic [DOUT_W-1:0] r_comb [N];
   logic [DOUT_W-1:0] r_dly  [N][M];
   logic [N-1:0]      r_vld;
   logic [DOUT_W-1:0] w_cx   [N];
   logic [N-1:0]      w_cen;

   always_comb begin
      w_cx     = '{default: '0};
      w_cen    = '0;
      w_cx[0]  = r_integ[N-1];
      w_cen[0] = r_strb;
      for (int k = 1; k < N; k++) begin
         w_cx[k]  = r_comb[k-1];
         w_cen[k] = r_vld[k-1];
      end
   end

   // Combs advance only with their valid bit, independent of en_i, so in-flight results keep draining.
   always_ff @(posedge clk_i or posedge w_rst) begin
      if (w_rst) begin
         r_vld <= '0;
         for (int k = 0; k < N; k++) begin
            r_comb[k] <= '0;
            for (int j = 0; j < M; j++) r_dly[k][j] <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            r_vld[k] <= w_cen[k];
            if (w_cen[k]) begin
               r_comb[k]   <= w_cx[k] - r_dly[k][M-1];
               r_dly[k][0] <= w_cx[k];
               for (int j = 1; j < M; j++) r_dly[k][j] <= r_dly[k][j-1];
            end
         end
      end
   end

   logic              r_valid;
   logic [DOUT_W-1:0] r_data;

   always_ff @(posedge clk_i or posedge w_rst) begin
      if (w_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= r_vld[N-1];
         if (r_vld[N-1]) r_data <= r_comb[N-1];
      end
   end

   assign valid_o = r_valid;
   assign data_o  = r_data;

endmodule

// File: tb/tb_cic_decimator.sv
// Randomised and directed bench for cic_decimator against a closed-form CIC reference model.
module tb_cic_decimator;

   localparam int DIN_W  = 11;
   localparam int N      = 3;
   localparam int R_MAX  = 8;
   localparam int M      = 1;
   localparam int RATE_W = 4;
   localparam int DOUT_W = DIN_W + N*$clog2(R_MAX*M);

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              en_i  = 1'b0;
   logic [DIN_W-1:0]  data_i = '0;
   logic [RATE_W-1:0] rate_i = RATE_W'(8);
   logic              valid_o;
   logic [DOUT_W-1:0] data_o;

   cic_decimator #(
      .DIN_W (DIN_W),
      .N     (N),
      .R_MAX (R_MAX),
      .M     (M),
      .RATE_W(RATE_W)
   ) u_dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (en_i),
      .data_i (data_i),
      .rate_i (rate_i),
      .valid_o(valid_o),
      .data_o (data_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: accepted-sample history, decimated integrator values, expected outputs
   typedef struct {
      longint due;
      longint val;
   } exp_t;

   longint samp[$];
   longint dec[$];
   exp_t   q[$];
   int     phase    = 0;
   int     act_rate = 0;
   longint cyc      = 0;
   longint last_out = 0;
   longint obs_log[$];
   longint vcyc_log[$];

   function automatic longint wrapv(input longint v);
      longint mask = (longint'(1) << DOUT_W) - 1;
      longint r = v & mask;
      if (((r >> (DOUT_W-1)) & 1) != 0) r = r - (longint'(1) << DOUT_W);
      return r;
   endfunction

   function automatic longint binom(input longint n, input int k);
      longint r = 1;
      if (n < 0 || n < k) return 0;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   function automatic int clamp_rate(input int r);
      return (r == 0 || r > R_MAX) ? R_MAX : r;
   endfunction

   // N-fold running sum of the input, in closed form
   function automatic longint integ_total();
      longint s = 0;
      int n = samp.size();
      for (int i = 0; i < n; i++) s += binom(longint'(n - 1 - i + N - 1), N - 1) * samp[i];
      return s;
   endfunction

   // N-th order difference with delay M over the decimated sequence
   function automatic longint comb_out();
      longint s = 0;
      int j = dec.size() - 1;
      for (int k = 0; k <= N; k++) begin
         int idx = j - k*M;
         if (idx >= 0) s += ((k % 2) ? -1 : 1) * binom(longint'(N), k) * dec[idx];
      end
      return wrapv(s);
   endfunction

   task automatic model_step(input logic en, input int d, input int rate);
      exp_t e;
      if (!en) return;
      if (act_rate == 0) act_rate = clamp_rate(rate);
      samp.push_back(longint'(d));
      if (phase == act_rate - 1) begin
         phase    = 0;
         act_rate = clamp_rate(rate);
         dec.push_back(integ_total());
         e.due = cyc + N + 1;
         e.val = comb_out();
         q.push_back(e);
      end else begin
         phase++;
      end
   endtask

   task automatic tick(input logic en, input int d, input int rate);
      en_i   = en;
      data_i = DIN_W'(d);
      rate_i = RATE_W'(rate);
      @(posedge clk_i);
      cyc++;
      model_step(en, d, rate);
      #1;
      if (valid_o === 1'b1) begin
         obs_log.push_back(longint'($signed(data_o)));
         vcyc_log.push_back(cyc);
      end
      if (q.size() > 0 && q[0].due == cyc) begin
         check("valid_hi", longint'(valid_o), 1);
         check("data_out", longint'($signed(data_o)), q[0].val);
         last_out = q[0].val;
         void'(q.pop_front());
      end else begin
         check("valid_lo", longint'(valid_o), 0);
         check("data_hold", longint'($signed(data_o)), last_out);
      end
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      en_i  = 1'b0;
      #1;
      check("rst_valid", longint'(valid_o), 0);
      check("rst_data", longint'($signed(data_o)), 0);
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      rst_i = 1'b0;
      samp.delete();
      dec.delete();
      q.delete();
      obs_log.delete();
      vcyc_log.delete();
      phase    = 0;
      act_rate = 0;
      last_out = 0;
      repeat (3) tick(1'b0, 0, 8);
   endtask

   function automatic longint obs_at(input int i);
      return (i >= 0 && i < obs_log.size()) ? obs_log[i] : -64'sd999999999;
   endfunction

   function automatic longint vcyc_at(input int i);
      return (i >= 0 && i < vcyc_log.size()) ? vcyc_log[i] : -64'sd1;
   endfunction

   function automatic longint obs_last();
      return (obs_log.size() > 0) ? obs_log[obs_log.size()-1] : -64'sd999999999;
   endfunction

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, n_vec=%0d", n_vec);
      $fatal(1, "timeout");
   end

   initial begin
      longint t0;
      int     hist[$];
      int     rate;

      @(negedge clk_i);
      do_reset();

      // DC 1 at rate 8, continuous
      t0 = cyc;
      repeat (40) tick(1'b1, 1, 8);
      repeat (6)  tick(1'b0, 0, 8);
      check("t1_out0", obs_at(0), 120);
      check("t1_out1", obs_at(1), 456);
      check("t1_out2", obs_at(2), 512);
      check("t1_out3", obs_at(3), 512);
      check("t1_first_lat", vcyc_at(0) - (t0 + 8), N + 1);
      check("t1_spacing", vcyc_at(1) - vcyc_at(0), 8);

      // full-scale DC inputs
      do_reset();
      repeat (64) tick(1'b1, -1024, 8);
      repeat (6)  tick(1'b0, 0, 8);
      check("t2_neg_fs", obs_last(), -524288);
      do_reset();
      repeat (64) tick(1'b1, 1023, 8);
      repeat (6)  tick(1'b0, 0, 8);
      check("t2_pos_fs", obs_last(), 523776);

      // en_i toggling
      do_reset();
      for (int i = 0; i < 80; i++) tick((i % 2) == 0, 1, 8);
      repeat (6) tick(1'b0, 0, 8);
      check("t3_out0", obs_at(0), 120);
      check("t3_out1", obs_at(1), 456);
      check("t3_out2", obs_at(2), 512);
      check("t3_spacing", vcyc_at(1) - vcyc_at(0), 16);

      // rate change 8 -> 4 mid-frame
      do_reset();
      repeat (5)  tick(1'b1, 1, 8);
      repeat (35) tick(1'b1, 1, 4);
      repeat (6)  tick(1'b0, 0, 4);
      check("t4_out0", obs_at(0), 120);
      check("t4_spacing", vcyc_at(1) - vcyc_at(0), 4);
      check("t4_settle", obs_last(), 64);

      // rate 1 ramp: output is the input delayed by N+1
      do_reset();
      for (int i = 0; i < 40; i++) begin
         int d = ((i * 37) % 2048) - 1024;
         hist.push_back(d);
         tick(1'b1, d, 1);
         if (i >= N + 1) begin
            check("t5_valid", longint'(valid_o), 1);
            check("t5_delay", longint'($signed(data_o)), longint'(hist[i - (N + 1)]));
         end
      end
      repeat (6) tick(1'b0, 0, 1);

      // reset with a result in flight, then reset while valid_o is high
      do_reset();
      repeat (10) tick(1'b1, 1, 8);
      do_reset();
      repeat (40) tick(1'b1, 1, 8);
      repeat (6)  tick(1'b0, 0, 8);
      check("t6_restart", obs_at(0), 120);
      for (int i = 0; i < 20 && valid_o !== 1'b1; i++) tick(1'b1, 1, 8);
      check("t6_vhigh", longint'(valid_o), 1);
      do_reset();

      // randomised traffic, including out-of-range rate requests
      rate = 8;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 19) == 0) rate = int'($urandom_range(0, 15));
         if (i == 250) do_reset();
         tick($urandom_range(0, 9) < 7, int'($urandom_range(0, 2047)) - 1024, rate);
      end
      repeat (8) tick(1'b0, 0, rate);
      check("t7_drained", longint'(q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
